neuron_weight_sequencer: RTL and testbench
==========================================

Name: neuron_weight_sequencer

Overview:
- Per-neuron controller that sequences one weight memory (numWeight x dataWidth ROM, 1-cycle registered read) against an incoming stream of input activations.
- For each accepted input it issues the matching weight read, multiplies the pair in Q-format, and accumulates the products with saturation.
- After the last input it adds the bias, saturates the sum to dataWidth and presents it for one cycle.
- Sits between the layer input bus and the activation function, one instance per neuron.

Parameters:
- numWeight, 30, inputs per neuron = weight memory depth
- addressWidth, $clog2(numWeight), weight address width
- dataWidth, 16, signed two's-complement width of inputs, weights, bias and result
- fracBits, 12, fractional bits of the Q format (1.0 = 4096)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input activation valid
- in_data  in  dataWidth  signed input activation
- in_ready  out  1  sequencer accepts input this cycle
- bias  in  dataWidth  signed bias, sampled in BIAS state
- w_ren  out  1  weight memory read enable
- w_radd  out  addressWidth  weight memory read address
- w_dout  in  dataWidth  weight memory read data, valid 1 cycle after w_ren
- out_valid  out  1  one-cycle result strobe
- out_data  out  dataWidth  saturated neuron sum

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port rst.
- Reset (asynchronous, any cycle, including mid-accumulation) forces:
  - state=ACCUM, count=0, acc=0, pipeline valids=0
  - out_valid=0, out_data=0
  - The partial sum is discarded.
- States: ACCUM -> DRAIN1 -> DRAIN2 -> BIAS -> OUT -> ACCUM.
- ACCUM:
  - in_ready=1.
  - Accept = in_valid & in_ready.
  - w_ren = accept (combinational); w_radd = count (registered).
  - On accept: count++ and in_data is registered into x_d with valid flag v1.
  - Bubbles (in_valid=0) are allowed anywhere; count holds.
  - The accept with count==numWeight-1 moves to DRAIN1 and clears count to 0.
- Non-ACCUM states: in_ready=0, w_ren=0, w_radd holds.
- Pipeline, for an accept at cycle t:
  - t+1: prod_r <= w_dout * x_d (full 2*dataWidth signed product), v2 <= v1.
  - t+2: if v2, acc <= sat_acc(acc + (prod_r >>> fracBits)).
- Arithmetic:
  - acc is 2*dataWidth signed.
  - The shift is arithmetic (floor toward -inf).
  - Accumulation saturates at the 2*dataWidth signed limits and never wraps.
- DRAIN1, DRAIN2: one cycle each; they flush the last product into acc.
- BIAS (one cycle):
  - out_data <= sat(acc + sign-extended bias) to [-2^(dataWidth-1), 2^(dataWidth-1)-1].
  - acc <= 0 in the same cycle.
- OUT: out_valid=1 for exactly one cycle, then ACCUM.
- Latency: last input accepted at cycle T -> out_valid high at T+4. The next input is accepted no earlier than T+5.
- out_data holds its value until the next BIAS state. out_valid is 0 outside OUT.
- The weight memory write port is not driven by this block.

Decomposition:
- Package fnn_pkg:
  - seq_state_t enum {ACCUM, DRAIN1, DRAIN2, BIAS, OUT}
  - functions sat_acc() and sat_out() (parameterised by width)
  - constant FRAC_BITS default.
- One natural sub-module, neuron_mac_datapath:
  - contains x_d, prod_r, v1/v2, acc, and bias add/saturate
  - the FSM, counter and memory-interface logic stay in neuron_weight_sequencer.

Test Plan:
- Nominal: all 30 weights=4096, in_data=512 x30 back-to-back, bias=0 -> single out_valid, out_data=15360, at 4 cycles after last accept.
- Bias/sign: same stimulus, bias=-15360 -> out_data=0. Weights=0xF000 (-4096), in_data=4096 x30 -> out_data=-32768 (negative saturation). Weights=4096, in_data=4096 x30 -> out_data=32767.
- Bubbles: nominal stimulus with in_valid toggling every other cycle plus a 10-cycle gap -> out_data=15360. w_radd sequence 0..29 with exactly 30 w_ren pulses; out_valid exactly once.
- Backpressure: hold in_valid=1 continuously across two neuron frames -> in_ready low for 4 cycles between frames. Second frame result is independent of the first (acc cleared): 15360 both times.
- Truncation: weight=1, in_data=-1 for all 30 -> each term = -1 (floor), out_data=-30.
- Reset mid-run: assert rst asynchronously after 10 accepts -> out_valid=0, out_data=0, w_radd=0 immediately. Then 30 fresh inputs -> out_data=15360.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared types and saturation helpers for the neuron sequencer.
// Q-format default and the sequencer state encoding live here.
package fnn_pkg;

  localparam int FRAC_BITS = 12;

  typedef enum logic [2:0] {
    ACCUM,
    DRAIN1,
    DRAIN2,
    BIAS,
    OUT
  } seq_state_t;

  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Accumulator clamps at 2*dw bits, the result at dw bits.
  function automatic logic signed [63:0] sat_acc(
    input logic signed [63:0] v,
    input int                 dw
  );
    return sat_w(v, 2 * dw);
  endfunction

  function automatic logic signed [63:0] sat_out(
    input logic signed [63:0] v,
    input int                 dw
  );
    return sat_w(v, dw);
  endfunction

endpackage

// File: rtl/neuron_weight_sequencer_if.sv
// Layer-input, weight-memory and result signals of one neuron.
// master = sequencer side, slave = environment side.
interface neuron_weight_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 5
);
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic signed [DW-1:0] bias;
  logic                 w_ren;
  logic [AW-1:0]        w_radd;
  logic signed [DW-1:0] w_dout;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;

  modport master (
    input  in_valid, in_data, bias, w_dout,
    output in_ready, w_ren, w_radd, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, bias, w_dout,
    input  in_ready, w_ren, w_radd, out_valid, out_data
  );
endinterface

// File: rtl/neuron_weight_sequencer_mac.sv
// Multiply-accumulate pipeline: input register, product register,
// saturating accumulator and the bias add onto the output register.
module neuron_mac_datapath
  import fnn_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int fracBits  = FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        accept,
  input  logic signed [dataWidth-1:0] in_data,
  input  logic signed [dataWidth-1:0] w_dout,
  input  logic                        bias_ld,
  input  logic signed [dataWidth-1:0] bias,
  output logic signed [dataWidth-1:0] out_data
);

  localparam int AW2 = 2 * dataWidth;

  logic signed [dataWidth-1:0] x_d;
  logic signed [AW2-1:0]       prod_r;
  logic signed [AW2-1:0]       acc;
  logic                        v1;
  logic                        v2;

  logic signed [63:0] acc_sum;
  logic signed [63:0] acc_sat;
  logic signed [63:0] out_sum;
  logic signed [63:0] out_sat;

  // Arithmetic shift floors toward -inf before the add.
  always_comb begin
    acc_sum = 64'(acc) + 64'(prod_r >>> fracBits);
    acc_sat = sat_acc(acc_sum, dataWidth);
    out_sum = 64'(acc) + 64'(bias);
    out_sat = sat_out(out_sum, dataWidth);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_d      <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      prod_r   <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) x_d <= in_data;
      prod_r <= AW2'(w_dout) * AW2'(x_d);
      if (bias_ld) begin
        out_data <= dataWidth'(out_sat);
        acc      <= '0;
      end else if (v2) begin
        acc <= AW2'(acc_sat);
      end
    end
  end

endmodule

// File: rtl/neuron_weight_sequencer.sv
// Per-neuron controller: paces weight reads against the input
// stream, then drains the MAC pipe, adds bias and strobes the result.
module neuron_weight_sequencer
  import fnn_pkg::*;
#(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int fracBits     = FRAC_BITS
) (
  input logic                       clk,
  input logic                       rst,
  neuron_weight_sequencer_if.master bus
);

  localparam logic [addressWidth-1:0] LAST =
    addressWidth'(numWeight - 1);

  seq_state_t              state;
  seq_state_t              nxt;
  logic [addressWidth-1:0] count;
  logic                    rdy;
  logic                    accept;
  logic                    bias_ld;

  assign rdy    = (state == ACCUM);
  assign accept = bus.in_valid & rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      state <= nxt;
      if (accept)
        count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  always_comb begin
    nxt     = state;
    bias_ld = 1'b0;
    unique case (state)
      ACCUM:  if (accept && count == LAST) nxt = DRAIN1;
      DRAIN1: nxt = DRAIN2;
      DRAIN2: nxt = BIAS;
      BIAS: begin
        bias_ld = 1'b1;
        nxt     = OUT;
      end
      OUT:    nxt = ACCUM;
      default: nxt = ACCUM;
    endcase
  end

  assign bus.in_ready  = rdy;
  assign bus.w_ren     = accept;
  assign bus.w_radd    = count;
  assign bus.out_valid = (state == OUT);

  neuron_mac_datapath #(
    .dataWidth (dataWidth),
    .fracBits  (fracBits)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .in_data  (bus.in_data),
    .w_dout   (bus.w_dout),
    .bias_ld  (bias_ld),
    .bias     (bus.bias),
    .out_data (bus.out_data)
  );

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// Self-checking bench: behavioural ROM and reference sum model,
// directed frames from the test plan plus randomized frames.
module tb_neuron_weight_sequencer;

  localparam int NW = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_weight_sequencer_if #(.DW(16), .AW(5)) bus ();

  neuron_weight_sequencer #(
    .numWeight (NW),
    .dataWidth (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [15:0] rom [NW];
  int                 xq [$];

  int checks = 0;
  int fails  = 0;

  int                 cyc = 0;
  int                 ren_cnt;
  int                 stall_cnt;
  int                 last_acc;
  int                 radd_q [$];
  logic signed [15:0] out_q [$];
  int                 lat_q [$];

  always @(posedge clk) begin
    cyc++;
    if (bus.w_ren) bus.w_dout <= rom[bus.w_radd];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.w_ren) begin
        ren_cnt++;
        radd_q.push_back(int'(bus.w_radd));
      end
      if (bus.in_valid && bus.in_ready) last_acc = cyc;
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.out_valid) begin
        out_q.push_back(bus.out_data);
        lat_q.push_back(cyc - last_acc);
      end
    end
  end

  function automatic logic signed [15:0] model(
    input int                 base,
    input logic signed [15:0] b
  );
    longint acc = 0;
    for (int i = 0; i < NW; i++) begin
      acc += (longint'(rom[i]) * longint'(xq[base + i])) >>> 12;
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    end
    acc += longint'(b);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic clr();
    ren_cnt   = 0;
    stall_cnt = 0;
    radd_q.delete();
    out_q.delete();
    lat_q.delete();
  endtask

  task automatic fill(input int w, input int x, input int n);
    xq.delete();
    for (int i = 0; i < NW; i++) rom[i] = 16'(w);
    for (int i = 0; i < n; i++) xq.push_back(x);
  endtask

  task automatic drive(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int gap = 0;
      int g   = 0;
      if (mode == 1) gap = (i % 2) + ((i == 15) ? 10 : 0);
      if (mode == 2 && $urandom_range(0, 3) == 0)
        gap = $urandom_range(1, 3);
      repeat (gap) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(xq[i]);
      @(negedge clk);
      while (!bus.in_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) begin
        checks++; fails++;
        $display("FAIL ready_timeout: item %0d never accepted", i);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (out_q.size() < n && g < 60) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.w_ren !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: ready=%b ren=%b want 1/0",
               bus.in_ready, bus.w_ren);
    end
    checks++;
    if (bus.w_radd !== 5'd0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: radd=%0d ov=%b want 0/0",
               bus.w_radd, bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 16'sd0) begin
      fails++;
      $display("FAIL reset_data: got %0d want 0", bus.out_data);
    end
  endtask

  task automatic test_nominal();
    logic signed [15:0] got;
    logic signed [15:0] exp;
    clr(); fill(4096, 512, NW); bus.bias = 16'sd0;
    exp = model(0, bus.bias);
    drive(NW, 0); wait_out(1);
    got = (out_q.size() > 0) ? out_q[0] : 'x;
    checks++;
    if (out_q.size() != 1 || got !== 16'sd15360 || got !== exp) begin
      fails++;
      $display("FAIL nominal: n=%0d got %0d want 15360",
               out_q.size(), got);
    end
    checks++;
    if (lat_q.size() < 1 || lat_q[0] != 4) begin
      fails++;
      $display("FAIL latency: got %0d want 4",
               (lat_q.size() > 0) ? lat_q[0] : -1);
    end
    checks++;
    if (bus.out_data !== got || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold: data=%0d ov=%b want %0d/0",
               bus.out_data, bus.out_valid, got);
    end
  endtask

  task automatic test_bias_sign();
    int                 wv [3] = '{4096, -4096, 4096};
    int                 xv [3] = '{512, 4096, 4096};
    int                 bv [3] = '{-15360, 0, 0};
    logic signed [15:0] want [3] = '{16'sd0, -16'sd32768, 16'sd32767};
    for (int k = 0; k < 3; k++) begin
      logic signed [15:0] got;
      clr(); fill(wv[k], xv[k], NW); bus.bias = 16'(bv[k]);
      drive(NW, 0); wait_out(1);
      got = (out_q.size() > 0) ? out_q[0] : 'x;
      checks++;
      if (out_q.size() != 1 || got !== want[k] ||
          got !== model(0, bus.bias)) begin
        fails++;
        $display("FAIL bias_sign[%0d]: got %0d want %0d",
                 k, got, want[k]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic signed [15:0] got;
    int                 bad = 0;
    clr(); fill(4096, 512, NW); bus.bias = 16'sd0;
    drive(NW, 1); wait_out(1);
    got = (out_q.size() > 0) ? out_q[0] : 'x;
    checks++;
    if (out_q.size() != 1 || got !== 16'sd15360) begin
      fails++;
      $display("FAIL bubbles: n=%0d got %0d want 15360",
               out_q.size(), got);
    end
    checks++;
    if (ren_cnt != NW) begin
      fails++;
      $display("FAIL ren_count: got %0d want %0d", ren_cnt, NW);
    end
    for (int i = 0; i < radd_q.size(); i++)
      if (radd_q[i] != i) bad++;
    checks++;
    if (bad != 0 || radd_q.size() != NW) begin
      fails++;
      $display("FAIL radd_seq: %0d bad of %0d want 0..29",
               bad, radd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    clr(); fill(4096, 512, 2 * NW); bus.bias = 16'sd0;
    drive(2 * NW, 0); wait_out(2);
    checks++;
    if (stall_cnt != 4) begin
      fails++;
      $display("FAIL stall: got %0d want 4", stall_cnt);
    end
    checks++;
    if (out_q.size() != 2 || out_q[0] !== 16'sd15360 ||
        out_q[1] !== 16'sd15360) begin
      fails++;
      $display("FAIL b2b: n=%0d got %0d,%0d want 15360,15360",
               out_q.size(),
               (out_q.size() > 0) ? out_q[0] : 16'sd0,
               (out_q.size() > 1) ? out_q[1] : 16'sd0);
    end
  endtask

  task automatic test_truncation();
    logic signed [15:0] got;
    clr(); fill(1, -1, NW); bus.bias = 16'sd0;
    drive(NW, 0); wait_out(1);
    got = (out_q.size() > 0) ? out_q[0] : 'x;
    checks++;
    if (out_q.size() != 1 || got !== -16'sd30) begin
      fails++;
      $display("FAIL trunc: got %0d want -30", got);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      logic signed [15:0] got;
      logic signed [15:0] exp;
      clr(); xq.delete();
      for (int i = 0; i < NW; i++) begin
        rom[i] = 16'($urandom_range(0, 65535));
        xq.push_back(int'($signed(16'($urandom_range(0, 65535)))));
      end
      bus.bias = 16'($urandom_range(0, 65535));
      exp = model(0, bus.bias);
      drive(NW, 2); wait_out(1);
      got = (out_q.size() > 0) ? out_q[0] : 'x;
      checks++;
      if (out_q.size() != 1 || got !== exp) begin
        fails++;
        $display("FAIL random[%0d]: got %0d want %0d", f, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] got;
    clr(); fill(4096, 512, NW); bus.bias = 16'sd0;
    drive(NW, 0); wait_out(1);
    clr(); drive(10, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'sd0 ||
        bus.w_radd !== 5'd0) begin
      fails++;
      $display("FAIL async_rst: ov=%b data=%0d radd=%0d want 0/0/0",
               bus.out_valid, bus.out_data, bus.w_radd);
    end
    @(posedge clk); #1 rst = 1'b0;
    clr(); drive(NW, 0); wait_out(1);
    got = (out_q.size() > 0) ? out_q[0] : 'x;
    checks++;
    if (out_q.size() != 1 || got !== 16'sd15360) begin
      fails++;
      $display("FAIL post_rst: got %0d want 15360", got);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.bias     = '0;
    bus.w_dout   = '0;
    for (int i = 0; i < NW; i++) rom[i] = '0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_nominal();
    test_bias_sign();
    test_bubbles();
    test_back_to_back();
    test_truncation();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
